vc_wb_buffer: RTL and testbench

- Write-back buffer directly downstream of the victim cache.
- Accepts dirty lines evicted from the victim cache, queues them, and drains them to physical memory one line at a time.
- Arbitrates memory access between the drain and line-fill reads issued on victim-cache misses.
- Serves a fill read directly from the buffer when a queued line matches its address.

---
 rtl/vc_wb_buffer.sv | 171 +++++++++++++++++
 tb/tb_vc_wb_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_wb_buffer.sv
// Write-back buffer behind the victim cache: queues evicted dirty lines, drains them to memory,
// and arbitrates memory with fill reads, forwarding fills that hit a queued line.
module vc_wb_buffer #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_line   = 256,
    parameter int unsigned depth    = 4,
    parameter int unsigned cnt_w    = $clog2(depth) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_addr,
    input  logic [s_line-1:0] in_line,
    output logic              in_ready,
    input  logic              rd_req,
    input  logic [31:0]       rd_addr,
    output logic [s_line-1:0] rd_rdata,
    output logic              rd_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [cnt_w-1:0]  count,
    output logic              empty
);

    localparam int unsigned TagW = 32 - s_offset;
    localparam int unsigned PtrW = $clog2(depth);

    typedef enum logic [1:0] {StIdle, StHit, StRdMem, StWrMem} state_e;

    state_e            state_q;
    logic [TagW-1:0]   tag_q  [depth];
    logic [s_line-1:0] data_q [depth];
    logic [depth-1:0]  valid_q;
    logic [PtrW-1:0]   head_q, tail_q;
    logic [cnt_w-1:0]  count_q;
    logic              rd_resp_q;
    logic [s_line-1:0] rd_rdata_q;

    logic [TagW-1:0] in_tag, rd_tag;
    logic            push, alloc, pop;
    logic            co_hit, rd_hit;
    logic [PtrW-1:0] co_idx, rd_idx, scan_idx;

    assign in_tag   = in_addr[31:s_offset];
    assign rd_tag   = rd_addr[31:s_offset];
    assign in_ready = (count_q != cnt_w'(depth));
    assign push     = in_valid && in_ready;
    assign alloc    = push && !co_hit;
    assign pop      = (state_q == StWrMem) && pmem_resp;

    // Scan oldest to youngest so the last match found is the youngest entry.
    always_comb begin
        co_hit   = 1'b0;
        co_idx   = '0;
        rd_hit   = 1'b0;
        rd_idx   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < depth; k++) begin
            scan_idx = head_q + PtrW'(k);
            if (valid_q[scan_idx] && tag_q[scan_idx] == in_tag &&
                !(state_q == StWrMem && scan_idx == head_q)) begin
                co_hit = 1'b1;
                co_idx = scan_idx;
            end
            if (valid_q[scan_idx] && tag_q[scan_idx] == rd_tag) begin
                rd_hit = 1'b1;
                rd_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (co_hit) begin
                data_q[co_idx] <= in_line;
            end else begin
                tag_q[tail_q]  <= in_tag;
                data_q[tail_q] <= in_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_resp_q  <= 1'b0;
            rd_rdata_q <= '0;
        end else begin
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PtrW'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
            count_q   <= count_q + cnt_w'(alloc) - cnt_w'(pop);
            rd_resp_q <= 1'b0;
            case (state_q)
                // rd_req is still high in the cycle rd_resp is shown; do not restart on it.
                StIdle: begin
                    if (count_q == cnt_w'(depth)) begin
                        state_q <= StWrMem;
                    end else if (rd_req && !rd_resp_q) begin
                        if (push && in_tag == rd_tag) begin
                            rd_rdata_q <= in_line;
                            state_q    <= StHit;
                        end else if (rd_hit) begin
                            rd_rdata_q <= data_q[rd_idx];
                            state_q    <= StHit;
                        end else begin
                            state_q <= StRdMem;
                        end
                    end else if (count_q != '0) begin
                        state_q <= StWrMem;
                    end
                end
                StHit: begin
                    rd_resp_q <= 1'b1;
                    state_q   <= StIdle;
                end
                StRdMem: begin
                    if (pmem_resp) begin
                        rd_rdata_q <= pmem_rdata;
                        rd_resp_q  <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                StWrMem: begin
                    if (pmem_resp) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state_q)
            StRdMem: begin
                pmem_read    = 1'b1;
                pmem_address = {rd_addr[31:s_offset], {s_offset{1'b0}}};
            end
            StWrMem: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[head_q], {s_offset{1'b0}}};
                pmem_wdata   = data_q[head_q];
            end
            default: ;
        endcase
    end

    assign rd_resp  = rd_resp_q;
    assign rd_rdata = rd_rdata_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule

// File: tb/tb_vc_wb_buffer.sv
// Directed bench for vc_wb_buffer: a cycle-by-cycle vector table plus a mid-drain reset sequence.
module tb_vc_wb_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [31:0]  in_addr;
    logic [255:0] in_line;
    logic         in_ready;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic [255:0] rd_rdata;
    logic         rd_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [2:0]   count;
    logic         empty;

    int n_cmp = 0;
    int n_bad = 0;

    vc_wb_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_addr      (in_addr),
        .in_line      (in_line),
        .in_ready     (in_ready),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_rdata     (rd_rdata),
        .rd_resp      (rd_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .count        (count),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic [7:0]  is;
        logic        rq;
        logic [31:0] ra;
        logic        pr;
        logic [7:0]  ps;
        logic [2:0]  ec;
        logic        erd;
        logic        ewr;
        logic [31:0] ea;
        logic [7:0]  ews;
        logic        ers;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [255:0] ln(input logic [7:0] s);
        return {32{s}};
    endfunction

    task automatic add(input logic iv, input logic [31:0] ia, input logic [7:0] is,
                       input logic rq, input logic [31:0] ra, input logic pr,
                       input logic [7:0] ps, input logic [2:0] ec, input logic erd,
                       input logic ewr, input logic [31:0] ea, input logic [7:0] ews,
                       input logic ers, input logic [7:0] err);
        vec_t v;
        v.iv = iv; v.ia = ia; v.is = is; v.rq = rq; v.ra = ra; v.pr = pr; v.ps = ps;
        v.ec = ec; v.erd = erd; v.ewr = ewr; v.ea = ea; v.ews = ews; v.ers = ers;
        v.err = err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_addr    = '0;
        in_line    = '0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 256'(count), 256'(0));
        check("rst_empty", 256'(empty), 256'(1));
        check("rst_ready", 256'(in_ready), 256'(1));
        check("rst_strobes", 256'({rd_resp, pmem_read, pmem_write}), 256'(0));
        check("rst_rdata", rd_rdata, 256'(0));
        check("rst_addr", 256'(pmem_address), 256'(0));
        check("rst_wdata", pmem_wdata, 256'(0));
        rst = 1'b0;

        // iv ia is | rq ra | pr ps | count rd wr addr wseed | resp rseed
        // single push, stalled drain, then release
        add(1, 'h1040, 'h11, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h1040, 'h11, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h1040, 'h11, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // coalesce A/L2 onto A/L1 with a read hit, then the single drain carries L2
        add(1, 'h1040, 'h21, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 'h1040, 'h22, 1, 'h105C, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 'h105C, 0, 0, 1, 0, 0, 0, 0, 1, 'h22);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h1040, 'h22, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // fill miss from memory
        add(0, 0, 0, 1, 'h2000, 0, 0, 0, 1, 0, 'h2000, 0, 0, 0);
        add(0, 0, 0, 1, 'h2000, 0, 0, 0, 1, 0, 'h2000, 0, 0, 0);
        add(0, 0, 0, 1, 'h2000, 1, 'h33, 0, 0, 0, 0, 0, 1, 'h33);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // read served before drain; push to draining head allocates; push+pop keeps count
        add(1, 'h3000, 'h44, 1, 'h4000, 0, 0, 1, 1, 0, 'h4000, 0, 0, 0);
        add(0, 0, 0, 1, 'h4000, 1, 'h55, 1, 0, 0, 0, 0, 1, 'h55);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h3000, 'h44, 0, 0);
        add(1, 'h3000, 'h46, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h3000, 'h46, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 'h99, 0, 0, 0, 0, 0, 0, 0);
        // fill to full, 5th push ignored, read waits for the drain
        add(1, 'h1000, 'h61, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 'h1100, 'h62, 0, 0, 0, 0, 2, 0, 1, 'h1000, 'h61, 0, 0);
        add(1, 'h1200, 'h63, 0, 0, 0, 0, 3, 0, 1, 'h1000, 'h61, 0, 0);
        add(1, 'h1300, 'h64, 0, 0, 0, 0, 4, 0, 1, 'h1000, 'h61, 0, 0);
        add(1, 'h1400, 'h65, 1, 'h5000, 0, 0, 4, 0, 1, 'h1000, 'h61, 0, 0);
        add(0, 0, 0, 1, 'h5000, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 'h5000, 0, 0, 3, 1, 0, 'h5000, 0, 0, 0);
        add(0, 0, 0, 1, 'h5000, 1, 'h66, 3, 0, 0, 0, 0, 1, 'h66);
        add(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 'h1100, 'h62, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        // stored-entry hit, then drain the rest
        add(0, 0, 0, 1, 'h1208, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 'h1208, 0, 0, 2, 0, 0, 0, 0, 1, 'h63);
        add(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 'h1200, 'h63, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h1300, 'h64, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid   = vecs[i].iv;
            in_addr    = vecs[i].ia;
            in_line    = ln(vecs[i].is);
            rd_req     = vecs[i].rq;
            rd_addr    = vecs[i].ra;
            pmem_resp  = vecs[i].pr;
            pmem_rdata = ln(vecs[i].ps);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), 256'(count), 256'(vecs[i].ec));
            check($sformatf("v%0d_ready", i), 256'(in_ready), 256'(vecs[i].ec != 3'd4));
            check($sformatf("v%0d_empty", i), 256'(empty), 256'(vecs[i].ec == 3'd0));
            check($sformatf("v%0d_pread", i), 256'(pmem_read), 256'(vecs[i].erd));
            check($sformatf("v%0d_pwrite", i), 256'(pmem_write), 256'(vecs[i].ewr));
            check($sformatf("v%0d_paddr", i), 256'(pmem_address), 256'(vecs[i].ea));
            check($sformatf("v%0d_pwdata", i), pmem_wdata, ln(vecs[i].ews));
            check($sformatf("v%0d_resp", i), 256'(rd_resp), 256'(vecs[i].ers));
            if (vecs[i].ers) begin
                check($sformatf("v%0d_rdata", i), rd_rdata, ln(vecs[i].err));
            end
        end
        idle_inputs();

        // reset in the middle of a drain discards the queued line
        in_valid = 1'b1;
        in_addr  = 32'h0000_7000;
        in_line  = ln(8'h77);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int n = 0; n < 10 && !pmem_write; n++) begin
            @(posedge clk);
            #1;
        end
        check("mr_drain_start", 256'(pmem_write), 256'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mr_count", 256'(count), 256'(0));
        check("mr_pwrite", 256'(pmem_write), 256'(0));
        check("mr_empty", 256'(empty), 256'(1));
        check("mr_ready", 256'(in_ready), 256'(1));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mr_no_redrain", 256'(pmem_write), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
